// File: rtl/change_dispenser.sv
// Pays out a change amount coin by coin through a ready/ack hopper, largest denomination first.
// Optional CHANGE_BCD_EN adds registered BCD digits of the remaining amount.
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       payback,
    input  logic             coin_ack,
    input  logic             fault_clr,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [5:0]       remaining,
    output logic [CNT_W-1:0] coin_cnt
`ifdef CHANGE_BCD_EN
    ,
    output logic [3:0]       rem_tens,
    output logic [3:0]       rem_ones
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        DISPENSE,
        DONE,
        FAULT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t state, state_nxt;

    logic [7:0]       tmo_cnt, tmo_cnt_nxt;
    logic             coin_valid_nxt;
    logic [1:0]       coin_sel_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             fault_nxt;
    logic [5:0]       remaining_nxt;
    logic [CNT_W-1:0] coin_cnt_nxt;

    logic [5:0]       denom;
    logic [5:0]       rem_after;
    logic [1:0]       sel_pick;
    logic             accept;
    logic             expire;

    always_comb begin
        case (coin_sel)
            2'd0:    denom = 6'd10;
            2'd1:    denom = 6'd5;
            2'd2:    denom = 6'd2;
            default: denom = 6'd1;
        endcase
    end

    always_comb begin
        if (remaining >= 6'd10)     sel_pick = 2'd0;
        else if (remaining >= 6'd5) sel_pick = 2'd1;
        else if (remaining >= 6'd2) sel_pick = 2'd2;
        else                        sel_pick = 2'd3;
    end

    // The first DISPENSE cycle only raises coin_valid; acks count once the coin is presented.
    // An ack coinciding with the last timeout cycle is taken, so expiry is masked by coin_ack.
    assign accept    = (state == DISPENSE) && coin_valid && coin_ack;
    assign expire    = (state == DISPENSE) && coin_valid && !coin_ack && (tmo_cnt == TMO_LAST);
    assign rem_after = remaining - denom;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            coin_valid <= 1'b0;
            coin_sel   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            remaining  <= '0;
            coin_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            coin_valid <= coin_valid_nxt;
            coin_sel   <= coin_sel_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            fault      <= fault_nxt;
            remaining  <= remaining_nxt;
            coin_cnt   <= coin_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = (payback == 6'd0) ? DONE : SELECT;
            SELECT:   state_nxt = DISPENSE;
            DISPENSE: begin
                if (accept)      state_nxt = (rem_after != 6'd0) ? SELECT : DONE;
                else if (expire) state_nxt = FAULT;
            end
            DONE:     state_nxt = IDLE;
            FAULT:    if (fault_clr) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tmo_cnt_nxt    = tmo_cnt;
        coin_valid_nxt = coin_valid;
        coin_sel_nxt   = coin_sel;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        fault_nxt      = fault;
        remaining_nxt  = remaining;
        coin_cnt_nxt   = coin_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    remaining_nxt = payback;
                    coin_cnt_nxt  = '0;
                    busy_nxt      = 1'b1;
                    tmo_cnt_nxt   = '0;
                end
            end
            SELECT: coin_sel_nxt = sel_pick;
            DISPENSE: begin
                if (!coin_valid) begin
                    coin_valid_nxt = 1'b1;
                end else if (coin_ack) begin
                    remaining_nxt  = rem_after;
                    coin_cnt_nxt   = coin_cnt + CNT_W'(1);
                    coin_valid_nxt = 1'b0;
                    tmo_cnt_nxt    = '0;
                end else if (expire) begin
                    coin_valid_nxt = 1'b0;
                    fault_nxt      = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            DONE: begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
            FAULT: begin
                if (fault_clr) begin
                    fault_nxt   = 1'b0;
                    busy_nxt    = 1'b0;
                    tmo_cnt_nxt = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef CHANGE_BCD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_tens <= '0;
            rem_ones <= '0;
        end else begin
            rem_tens <= 4'(remaining_nxt / 6'd10);
            rem_ones <= 4'(remaining_nxt % 6'd10);
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of payout sessions plus hand-written corner sequences.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] payback;
    logic       coin_ack;
    logic       fault_clr;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       fault;
    logic [5:0] remaining;
    logic [3:0] coin_cnt;
`ifdef CHANGE_BCD_EN
    logic [3:0] rem_tens;
    logic [3:0] rem_ones;
`endif

    int compared   = 0;
    int mismatched = 0;

    change_dispenser #(
        .ACK_TIMEOUT(8),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .payback   (payback),
        .coin_ack  (coin_ack),
        .fault_clr (fault_clr),
        .coin_valid(coin_valid),
        .coin_sel  (coin_sel),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .remaining (remaining),
        .coin_cnt  (coin_cnt)
`ifdef CHANGE_BCD_EN
        ,
        .rem_tens  (rem_tens),
        .rem_ones  (rem_ones)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pay;
        int          delay;
        int          n;
        logic [17:0] seq;
        int          restart;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int denom_of(input logic [1:0] s);
        case (s)
            2'd0:    return 10;
            2'd1:    return 5;
            2'd2:    return 2;
            default: return 1;
        endcase
    endfunction

    task automatic wait_valid();
        int waitc = 0;
        while (!coin_valid && waitc < 20) begin
            tick();
            waitc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          exp_rem;
        int          waitc;
        logic [1:0]  exp_sel;
        payback = 6'(v.pay);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("rem_latched", int'(remaining), v.pay);
        check("cnt_cleared", int'(coin_cnt), 0);
        exp_rem = v.pay;
        for (int i = 0; i < v.n; i++) begin
            wait_valid();
            check("valid_wait", int'(coin_valid), 1);
            if (!coin_valid) return;
            exp_sel = v.seq[2*i +: 2];
            check("coin_sel", int'(coin_sel), int'(exp_sel));
            if (i == v.restart) begin
                start   = 1'b1;
                payback = 6'd5;
            end
            for (int d = 0; d < v.delay; d++) begin
                tick();
                start = 1'b0;
                check("valid_hold", int'(coin_valid), 1);
                check("sel_hold", int'(coin_sel), int'(exp_sel));
            end
            coin_ack = 1'b1;
            tick();
            coin_ack = 1'b0;
            start    = 1'b0;
            exp_rem -= denom_of(exp_sel);
            check("valid_drop", int'(coin_valid), 0);
            check("rem_after_coin", int'(remaining), exp_rem);
            check("cnt_after_coin", int'(coin_cnt), i + 1);
        end
        waitc = 0;
        while (!done && waitc < 10) begin
            check("no_extra_coin", int'(coin_valid), 0);
            tick();
            waitc++;
        end
        check("done_pulse", int'(done), 1);
        check("final_rem", int'(remaining), 0);
        check("final_cnt", int'(coin_cnt), v.n);
        tick();
        check("done_single", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v3;

        // seq packs coin i into bits [2i+1:2i]; highest index first in the literals
        vecs[0] = '{pay: 38, delay: 0, n: 6, restart: -1,
                    seq: {2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0}};
        vecs[1] = '{pay: 7, delay: 5, n: 2, restart: -1,
                    seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[2] = '{pay: 63, delay: 0, n: 8, restart: 2,
                    seq: {2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[3] = '{pay: 1, delay: 1, n: 1, restart: -1,
                    seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[4] = '{pay: 19, delay: 2, n: 4, restart: -1,
                    seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0}};
        vecs[5] = '{pay: 4, delay: 3, n: 2, restart: -1,
                    seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2}};
        v3 = '{pay: 3, delay: 0, n: 2, restart: -1,
               seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2}};

        rst_n     = 1'b0;
        start     = 1'b0;
        payback   = 6'd0;
        coin_ack  = 1'b0;
        fault_clr = 1'b0;
        tick();
        tick();
        check("rst_valid", int'(coin_valid), 0);
        check("rst_sel", int'(coin_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_rem", int'(remaining), 0);
        check("rst_cnt", int'(coin_cnt), 0);
        rst_n = 1'b1;
        tick();

        run_vec(vecs[0]);

        // coin_ack while idle must not touch the session record
        coin_ack = 1'b1;
        tick();
        tick();
        coin_ack = 1'b0;
        check("idle_ack_cnt", int'(coin_cnt), 6);
        check("idle_ack_rem", int'(remaining), 0);
        check("idle_ack_valid", int'(coin_valid), 0);
        check("idle_ack_busy", int'(busy), 0);

        for (int k = 1; k < 6; k++) run_vec(vecs[k]);

        // zero payback: DONE directly, done one edge later, busy for one cycle
        payback = 6'd0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("zero_busy", int'(busy), 1);
        check("zero_done_early", int'(done), 0);
        check("zero_cnt", int'(coin_cnt), 0);
        tick();
        check("zero_done", int'(done), 1);
        check("zero_busy_off", int'(busy), 0);
        check("zero_valid", int'(coin_valid), 0);
        tick();
        check("zero_done_off", int'(done), 0);

        // hopper never acks: fault after ACK_TIMEOUT cycles of coin_valid
        payback = 6'd10;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_valid();
        check("tmo_valid", int'(coin_valid), 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                check("tmo_nofault", int'(fault), 0);
                check("tmo_hold", int'(coin_valid), 1);
            end
        end
        check("tmo_fault", int'(fault), 1);
        check("tmo_valid_off", int'(coin_valid), 0);
        check("tmo_rem", int'(remaining), 10);
        check("tmo_cnt", int'(coin_cnt), 0);
        check("tmo_busy", int'(busy), 1);
        payback = 6'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        check("fault_sticky", int'(fault), 1);
        check("fault_start_ign", int'(remaining), 10);
        check("fault_no_valid", int'(coin_valid), 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_fault", int'(fault), 0);
        check("clr_busy", int'(busy), 0);

        // ack on the last timeout cycle wins over expiry
        payback = 6'd2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_valid();
        for (int k = 1; k <= 7; k++) tick();
        check("race_pre_valid", int'(coin_valid), 1);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check("race_nofault", int'(fault), 0);
        check("race_rem", int'(remaining), 0);
        check("race_cnt", int'(coin_cnt), 1);
        tick();
        check("race_done", int'(done), 1);
        tick();

        // asynchronous reset while a coin is presented
        payback = 6'd20;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_valid();
        check("arst_pre_valid", int'(coin_valid), 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(coin_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_rem", int'(remaining), 0);
        check("arst_cnt", int'(coin_cnt), 0);
        check("arst_sel", int'(coin_sel), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(v3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
